// File: rtl/cdb_result_queue.sv
// Completion queue feeding the N-wide CDB in strict arrival order, with a same-cycle
// bypass that places accepted inputs on free lanes behind the older buffered entries.
module cdb_result_queue #(
  parameter int DEPTH      = 16,
  parameter int CDB_WIDTH  = 3,
  parameter int NUM_INPUTS = 6,
  parameter int TAG_W      = 6,
  parameter int DATA_W     = 32,
  parameter int AF_THRESH  = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_flush,
  input  logic [NUM_INPUTS-1:0]           i_fu_valid,
  input  logic [NUM_INPUTS*TAG_W-1:0]     i_fu_tag,
  input  logic [NUM_INPUTS*DATA_W-1:0]    i_fu_data,
  output logic [NUM_INPUTS-1:0]           o_fu_ready,
  output logic [CDB_WIDTH-1:0]            o_cdb_valid,
  output logic [CDB_WIDTH*TAG_W-1:0]      o_cdb_tag,
  output logic [CDB_WIDTH*DATA_W-1:0]     o_cdb_data,
  input  logic [CDB_WIDTH-1:0]            i_cdb_rdy,
  output logic [$clog2(DEPTH+1)-1:0]      o_count,
  output logic                            o_empty,
  output logic                            o_full,
  output logic                            o_almost_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [TAG_W-1:0]  r_tag  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count;

  logic                  w_block;
  logic [NUM_INPUTS-1:0] w_acc;
  logic [NUM_INPUTS-1:0] w_wr_en;
  logic [PW-1:0]         w_wr_idx [NUM_INPUTS];
  logic [PW-1:0]         w_head_nxt, w_tail_nxt;
  logic [CW-1:0]         w_count_nxt;

  // Operands are always below DEPTH, so one conditional subtract suffices.
  function automatic logic [PW-1:0] f_wrap(input int base, input int off);
    int s;
    s = base + off;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  assign w_block = rst | i_flush;

  always_comb begin : admission
    int free;
    int nv;
    free = DEPTH - int'(r_count);
    nv = 0;
    o_fu_ready = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (i_fu_valid[i]) nv = nv + 1;
      o_fu_ready[i] = !w_block && (free >= nv);
    end
  end

  assign w_acc = i_fu_valid & o_fu_ready;

  always_comb begin : stream
    int   cnt, pos, nacc, d, base, nwr;
    logic stop;
    cnt = int'(r_count);
    o_cdb_valid = '0;
    o_cdb_tag   = '0;
    o_cdb_data  = '0;
    w_wr_en     = '0;
    for (int i = 0; i < NUM_INPUTS; i++) w_wr_idx[i] = '0;

    if (!w_block) begin
      for (int k = 0; k < CDB_WIDTH; k++) begin
        if (k < cnt) begin
          o_cdb_valid[k] = 1'b1;
          o_cdb_tag[k*TAG_W +: TAG_W]    = r_tag[f_wrap(int'(r_head), k)];
          o_cdb_data[k*DATA_W +: DATA_W] = r_data[f_wrap(int'(r_head), k)];
        end
      end
    end

    // Accepted inputs follow the buffered entries in port-index order.
    pos = cnt;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (w_acc[i]) begin
        for (int k = 0; k < CDB_WIDTH; k++) begin
          if (pos == k) begin
            o_cdb_valid[k] = 1'b1;
            o_cdb_tag[k*TAG_W +: TAG_W]    = i_fu_tag[i*TAG_W +: TAG_W];
            o_cdb_data[k*DATA_W +: DATA_W] = i_fu_data[i*DATA_W +: DATA_W];
          end
        end
        pos = pos + 1;
      end
    end
    nacc = pos - cnt;

    d = 0;
    stop = 1'b0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      if (!stop && o_cdb_valid[k] && i_cdb_rdy[k]) d = d + 1;
      else stop = 1'b1;
    end

    // Inputs not consumed by the CDB land at tail, packed in stream order.
    base = (d > cnt) ? d : cnt;
    pos = cnt;
    nwr = 0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (w_acc[i]) begin
        if (pos >= d) begin
          w_wr_en[i]  = 1'b1;
          w_wr_idx[i] = f_wrap(int'(r_tail), pos - base);
          nwr = nwr + 1;
        end
        pos = pos + 1;
      end
    end

    w_head_nxt  = f_wrap(int'(r_head), (d < cnt) ? d : cnt);
    w_tail_nxt  = f_wrap(int'(r_tail), nwr);
    w_count_nxt = CW'(cnt + nacc - d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (w_wr_en[i]) begin
        r_tag[w_wr_idx[i]]  <= i_fu_tag[i*TAG_W +: TAG_W];
        r_data[w_wr_idx[i]] <= i_fu_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign o_count       = r_count;
  assign o_empty       = (r_count == '0);
  assign o_full        = (r_count == CW'(DEPTH));
  assign o_almost_full = (int'(r_count) >= AF_THRESH);

endmodule
